sha256_msg_sched_ctrl: RTL and testbench

Sequencer for the SHA-256 message-expansion unit. It accepts one 512-bit block as 16 words over a valid/ready stream and writes them into the expansion unit. It then steps the expansion unit through rounds 0..63, offering each W[t] to the compression core under backpressure, and signals completion. It sits between the block-input FIFO and the expansion/compression pair, and produces the `fsm`/`count` codes the expansion unit decodes.

---
 rtl/sha256_pkg.sv | 19 +
 rtl/sha256_round_counter.sv | 23 ++
 rtl/sha256_msg_sched_ctrl.sv | 88 ++++++++
 tb/tb_sha256_msg_sched_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: expansion-unit mode codes, sequencer states, block geometry.
package sha256_pkg;

  localparam int SHA256_ROUNDS      = 64;
  localparam int SHA256_BLOCK_WORDS = 16;

  // Mode codes decoded by the message-expansion unit
  localparam logic [2:0] ME_HOLD   = 3'b000;
  localparam logic [2:0] ME_WRITE  = 3'b010;
  localparam logic [2:0] ME_EXPAND = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/sha256_round_counter.sv
// 7-bit word/round counter: synchronous clear beats increment, compare against a terminal value.
module sha256_round_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic [6:0] term,
  output logic [6:0] cnt,
  output logic       at_term
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 7'd1;
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/sha256_msg_sched_ctrl.sv
// Loads 16 words into the message-expansion unit, then steps it through the rounds while the
// compression core drains W[t] under backpressure; pulses done_out once the block is consumed.
module sha256_msg_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = SHA256_BLOCK_WORDS,
  parameter int ROUNDS      = SHA256_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  blk_valid_in,
  input  logic [DATA_WIDTH-1:0] blk_data_in,
  output logic                  blk_ready_out,
  output logic [2:0]            me_fsm_out,
  output logic [6:0]            me_count_out,
  output logic [DATA_WIDTH-1:0] me_data_out,
  input  logic                  w_ready_in,
  output logic                  w_valid_out,
  output logic [5:0]            round_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [6:0] BLK_LAST = 7'(BLOCK_WORDS - 1);
  localparam logic [6:0] RND_LAST = 7'(ROUNDS - 1);

  sched_state_t state;
  logic [6:0]   cnt;
  logic [6:0]   term;
  logic         at_term;
  logic         blk_acc;
  logic         w_acc;
  logic         cnt_inc;
  logic         cnt_clr;

  assign blk_acc = (state == ST_LOAD)   && blk_valid_in && !abort_in;
  assign w_acc   = (state == ST_EXPAND) && w_ready_in   && !abort_in;
  assign term    = (state == ST_LOAD) ? BLK_LAST : RND_LAST;
  assign cnt_inc = blk_acc || w_acc;
  // Counter restarts at zero on every phase boundary and whenever no block is in flight
  assign cnt_clr = abort_in || (state == ST_IDLE) || (state == ST_DONE) || (cnt_inc && at_term);

  sha256_round_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .term    (term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (abort_in) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_in)          state <= ST_LOAD;
        ST_LOAD:   if (blk_acc && at_term) state <= ST_EXPAND;
        ST_EXPAND: if (w_acc && at_term)   state <= ST_DONE;
        default:                           state <= ST_IDLE;
      endcase
    end
  end

  // A stalled EXPAND cycle re-issues the same index; recomputing W[cnt] is idempotent
  always_comb begin
    me_fsm_out = ME_HOLD;
    if (blk_acc)
      me_fsm_out = ME_WRITE;
    else if (state == ST_EXPAND)
      me_fsm_out = ME_EXPAND;
  end

  assign me_count_out  = cnt;
  assign me_data_out   = blk_acc ? blk_data_in : '0;
  assign blk_ready_out = (state == ST_LOAD) && !abort_in;
  assign w_valid_out   = (state == ST_EXPAND) && !abort_in;
  assign round_out     = (state == ST_EXPAND) ? cnt[5:0] : 6'd0;
  assign busy_out      = (state != ST_IDLE);
  assign done_out      = (state == ST_DONE) && !abort_in;

endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// Randomized bench for sha256_msg_sched_ctrl: block-level reference model plus an
// expansion-unit model fed by the DUT's mode codes, checked every cycle.
module tb_sha256_msg_sched_ctrl;
  import sha256_pkg::*;

  localparam int DW = 32;
  localparam int P_IDLE = 0, P_LOAD = 1, P_EXP = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_in, abort_in, blk_valid_in, w_ready_in;
  logic [DW-1:0] blk_data_in;
  logic          blk_ready_out, w_valid_out, busy_out, done_out;
  logic [2:0]    me_fsm_out;
  logic [6:0]    me_count_out;
  logic [DW-1:0] me_data_out;
  logic [5:0]    round_out;

  always #5 clk = ~clk;

  sha256_msg_sched_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start_in),
    .abort_in     (abort_in),
    .blk_valid_in (blk_valid_in),
    .blk_data_in  (blk_data_in),
    .blk_ready_out(blk_ready_out),
    .me_fsm_out   (me_fsm_out),
    .me_count_out (me_count_out),
    .me_data_out  (me_data_out),
    .w_ready_in   (w_ready_in),
    .w_valid_out  (w_valid_out),
    .round_out    (round_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Current block and its full message schedule
  logic [31:0] words[16];
  logic [31:0] sched[64];
  // Expansion-unit storage, written only through the DUT's mode codes
  logic [31:0] u[64];

  function automatic void compute_sched();
    for (int t = 0; t < 16; t++) sched[t] = words[t];
    for (int t = 16; t < 64; t++)
      sched[t] = ss1(sched[t-2]) + sched[t-7] + ss0(sched[t-15]) + sched[t-16];
  endfunction

  function automatic logic [31:0] unit_expand(input int t);
    return ss1(u[t-2]) + u[t-7] + ss0(u[t-15]) + u[t-16];
  endfunction

  // Block-level model: which phase the sequencer is in and which word/round it is on
  int m_phase;
  int m_idx;
  int cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_idx   <= 0;
    end else if (abort_in) begin
      m_phase <= P_IDLE;
      m_idx   <= 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start_in) begin m_phase <= P_LOAD; m_idx <= 0; end
        P_LOAD: if (blk_valid_in) begin
          if (m_idx == SHA256_BLOCK_WORDS - 1) begin m_phase <= P_EXP; m_idx <= 0; end
          else m_idx <= m_idx + 1;
        end
        P_EXP: if (w_ready_in) begin
          if (m_idx == SHA256_ROUNDS - 1) begin m_phase <= P_DONE; m_idx <= 0; end
          else m_idx <= m_idx + 1;
        end
        default: begin m_phase <= P_IDLE; m_idx <= 0; end
      endcase
    end
  end

  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] cap16;

  // Per-cycle compare, sampled on the falling edge
  initial begin
    logic        acc;
    logic [2:0]  e_fsm;
    logic [6:0]  e_cnt;
    logic [5:0]  e_rnd, g_rnd;
    logic [31:0] e_dat, g_dat, wv;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        acc   = (m_phase == P_LOAD) && !abort_in && blk_valid_in;
        e_fsm = acc ? ME_WRITE : (m_phase == P_EXP) ? ME_EXPAND : ME_HOLD;
        e_cnt = (m_phase == P_LOAD || m_phase == P_EXP) ? 7'(m_idx) : 7'd0;
        e_rnd = (m_phase == P_EXP) ? 6'(m_idx) : 6'd0;
        g_rnd = (m_phase == P_EXP) ? round_out : 6'd0;
        e_dat = acc ? blk_data_in : 32'd0;
        g_dat = acc ? me_data_out : 32'd0;
        chk("cycle_outputs",
            64'({blk_ready_out, me_fsm_out, me_count_out, w_valid_out, busy_out, done_out, g_rnd, g_dat}),
            64'({(m_phase == P_LOAD) && !abort_in, e_fsm, e_cnt,
                 (m_phase == P_EXP) && !abort_in, m_phase != P_IDLE,
                 (m_phase == P_DONE) && !abort_in, e_rnd, e_dat}));
        if (done_out) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (me_fsm_out == ME_EXPAND) begin
          wv = (me_count_out < 7'd16) ? u[me_count_out[5:0]] : unit_expand(int'(me_count_out[5:0]));
          if (w_valid_out) chk("w_value", 64'(wv), 64'(sched[m_idx]));
          if (m_phase == P_EXP && m_idx == 16) cap16 = wv;
          u[me_count_out[5:0]] = wv;
        end else if (me_fsm_out == ME_WRITE) begin
          u[me_count_out[5:0]] = me_data_out;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 none, 1 gap before every word, 2 random gaps
  task automatic run_block(input int gap_mode, input int stall_at, input int stall_len,
                           input bit ready_rand, input int abort_at, input int start_mid);
    int  d0, s, extra, stalls_left, it;
    bit  gap_next, aborted, v, r;
    d0 = done_cnt;
    compute_sched();
    start_in = 1'b1;
    tick();
    s = cyc;
    start_in = 1'b0;
    extra = 0;
    gap_next = 1'b1;
    stalls_left = stall_len;
    aborted = 1'b0;
    it = 0;
    while (m_phase != P_IDLE && it < 400) begin
      blk_valid_in = 1'b0;
      w_ready_in   = 1'b0;
      abort_in     = 1'b0;
      start_in     = 1'b0;
      blk_data_in  = $urandom;
      if (m_phase == P_LOAD) begin
        if (gap_mode == 1) begin
          v = !gap_next;
          gap_next = !gap_next;
        end else if (gap_mode == 2) v = ($urandom_range(0, 2) != 0);
        else v = 1'b1;
        if (!v) extra++;
        blk_valid_in = v;
        if (v) blk_data_in = words[m_idx];
      end else if (m_phase == P_EXP) begin
        if (m_idx == abort_at) begin
          abort_in = 1'b1;
          aborted  = 1'b1;
        end
        r = 1'b1;
        if (m_idx == stall_at && stalls_left > 0) begin
          r = 1'b0;
          stalls_left--;
        end else if (ready_rand) r = ($urandom_range(0, 3) != 0);
        if (!r) extra++;
        w_ready_in = r;
        if (m_idx == start_mid) begin
          start_in = 1'b1;
          start_mid = -1;
        end
      end
      tick();
      it++;
    end
    blk_valid_in = 1'b0;
    w_ready_in   = 1'b0;
    abort_in     = 1'b0;
    start_in     = 1'b0;
    chk("block_ends_idle", 64'(m_phase), 64'(P_IDLE));
    chk("busy_after_block", 64'(busy_out), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), aborted ? 64'd0 : 64'd1);
    if (!aborted) chk("done_latency", 64'(done_cyc - s + 1), 64'(81 + extra));
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) words[i] = $urandom;
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 64; i++) u[i] = 32'd0;
    rst_n = 1'b0;
    start_in = 1'b0;
    abort_in = 1'b0;
    blk_valid_in = 1'b0;
    w_ready_in = 1'b0;
    blk_data_in = '0;
    #12;
    chk("reset_outputs",
        64'({blk_ready_out, me_fsm_out, me_count_out, me_data_out, w_valid_out, round_out, busy_out, done_out}),
        64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // "abc" block, no stalls, then an immediate second block
    for (int i = 0; i < 16; i++) words[i] = 32'd0;
    words[0]  = 32'h61626380;
    words[15] = 32'h00000018;
    compute_sched();
    chk("model_abc_w16", 64'(sched[16]), 64'h61626380);
    chk("model_abc_w17", 64'(sched[17]), 64'h000f0000);
    run_block(0, -1, 0, 1'b0, -1, -1);
    chk("abc_w16_from_unit", 64'(cap16), 64'h61626380);
    rand_words();
    run_block(0, -1, 0, 1'b0, -1, -1);

    // Gap before every input word
    rand_words();
    run_block(1, -1, 0, 1'b0, -1, -1);

    // Five-cycle compression stall at round 20
    rand_words();
    run_block(0, 20, 5, 1'b0, -1, -1);

    // Abort at round 40, then a clean block
    rand_words();
    run_block(0, -1, 0, 1'b0, 40, -1);
    rand_words();
    run_block(0, -1, 0, 1'b0, -1, -1);

    // Asynchronous reset in the middle of LOAD
    rand_words();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      blk_valid_in = 1'b1;
      blk_data_in  = words[i];
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midload_reset_outputs",
        64'({blk_ready_out, me_fsm_out, me_count_out, me_data_out, w_valid_out, round_out, busy_out, done_out}),
        64'd0);
    blk_valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // start_in during EXPAND must be ignored
    rand_words();
    run_block(0, -1, 0, 1'b0, -1, 30);
    repeat (3) tick();
    chk("idle_after_ignored_start", 64'(busy_out), 64'd0);

    // Randomized gaps and backpressure
    for (int b = 0; b < 6; b++) begin
      rand_words();
      run_block(2, -1, 0, 1'b1, -1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
